// File: rtl/tmr_fault_manager.sv
// -----------------------------------------------------------------------------
// tmr_fault_manager
//
// Sequencing and fault-management controller for a triplicated counter
// datapath. It gates the shared count enable, watches the per-lane mismatch
// flags coming out of the voter, and schedules a force-load-from-vote
// (resync) of a lane that disagrees. A lane that keeps disagreeing is masked
// out. Counting halts when the vote can no longer be trusted: two lanes
// disagree at once, or any lane disagrees after one is already masked.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   run_req        system request to count
//   fault[2:0]     per-lane mismatch flags (bit i = lane i+1)
//   clear_err      single-cycle clear / recovery request
//   cnt_enable     count enable to all three replicas (combinational)
//   resync[2:0]    per-lane force-load-from-vote strobe
//   lane_mask[2:0] 1 = lane excluded (failed)
//   state[1:0]     RUN=00, RESYNC=01, DEGRADED=10, HALT=11 (debug view of FSM)
//   err_count      saturating count of correctable fault events
//   uncorrectable  sticky uncorrectable-condition flag
// -----------------------------------------------------------------------------
module tmr_fault_manager #(
  parameter int WIDTH         = 4,
  parameter int ERR_CNT_W     = 8,
  parameter int PERSIST_LIMIT = 4,
  parameter int RESYNC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_req,
  input  logic [2:0]           fault,
  input  logic                 clear_err,
  output logic                 cnt_enable,
  output logic [2:0]           resync,
  output logic [2:0]           lane_mask,
  output logic [1:0]           state,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 uncorrectable
);

  // Persistence counters must be able to hold PERSIST_LIMIT itself, because
  // the incremented value is compared against the limit before it is stored.
  localparam int PW = $clog2(PERSIST_LIMIT + 1);
  localparam int TW = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;

  // Elaboration-time guards on the parameter ranges this controller supports.
  if (WIDTH < 1) begin : g_bad_width
    $error("tmr_fault_manager: WIDTH must be >= 1");
  end
  if (PERSIST_LIMIT < 2) begin : g_bad_persist
    $error("tmr_fault_manager: PERSIST_LIMIT must be >= 2");
  end
  if (RESYNC_CYCLES < 1) begin : g_bad_resync
    $error("tmr_fault_manager: RESYNC_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_RESYNC   = 2'b01,
    ST_DEGRADED = 2'b10,
    ST_HALT     = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2:0]             resync_q, resync_d;
  logic [2:0]             lane_mask_q, lane_mask_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic                   unc_q, unc_d;
  logic [2:0][PW-1:0]     persist_q, persist_d;

  logic [2:0]             fault_eff;
  logic [1:0]             fault_cnt;
  logic [ERR_CNT_W-1:0]   err_base;
  logic [ERR_CNT_W-1:0]   err_sat_inc;
  logic [PW-1:0]          persist_inc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      timer_q     <= '0;
      resync_q    <= '0;
      lane_mask_q <= '0;
      err_count_q <= '0;
      unc_q       <= 1'b0;
      persist_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      resync_q    <= resync_d;
      lane_mask_q <= lane_mask_d;
      err_count_q <= err_count_d;
      unc_q       <= unc_d;
      persist_q   <= persist_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    resync_d    = resync_q;
    lane_mask_d = lane_mask_q;
    unc_d       = unc_q;
    persist_d   = persist_q;
    persist_inc = '0;

    // A masked lane no longer takes part in fault evaluation.
    fault_eff = fault & ~lane_mask_q;
    fault_cnt = {1'b0, fault_eff[0]} + {1'b0, fault_eff[1]} + {1'b0, fault_eff[2]};

    // clear_err outside HALT zeroes the counter first; a correctable event
    // in the same cycle then counts on top of the cleared value.
    err_base    = clear_err ? '0 : err_count_q;
    err_sat_inc = (&err_base) ? err_base : err_base + 1'b1;
    err_count_d = (state_q == ST_HALT) ? err_count_q : err_base;

    unique case (state_q)
      ST_RUN: begin
        if (fault_cnt == 2'd0) begin
          persist_d = '0;
        end else if (fault_cnt == 2'd1) begin
          err_count_d = err_sat_inc;
          for (int i = 0; i < 3; i++) begin
            if (fault_eff[i]) begin
              persist_inc = persist_q[i] + PW'(1);
              if (persist_inc >= PW'(PERSIST_LIMIT)) begin
                // Persistent offender: drop it from the vote instead of
                // resyncing it yet again.
                lane_mask_d[i] = 1'b1;
                persist_d[i]   = '0;
                state_d        = ST_DEGRADED;
              end else begin
                persist_d[i] = persist_inc;
                resync_d     = fault_eff;
                timer_d      = TW'(RESYNC_CYCLES - 1);
                state_d      = ST_RESYNC;
              end
            end
          end
        end else begin
          // Two or more lanes disagree with the vote: the majority is not
          // trustworthy, so stop counting.
          unc_d   = 1'b1;
          state_d = ST_HALT;
        end
      end

      ST_RESYNC: begin
        // Faults are ignored here; the lane(s) are being reloaded.
        if (timer_q == '0) begin
          resync_d = '0;
          state_d  = (|lane_mask_q) ? ST_DEGRADED : ST_RUN;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_DEGRADED: begin
        // Only two lanes remain, so any disagreement is unresolvable.
        if (|fault_eff) begin
          unc_d   = 1'b1;
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        if (clear_err) begin
          unc_d       = 1'b0;
          lane_mask_d = '0;
          err_count_d = '0;
          persist_d   = '0;
          // Recover by reloading every lane from the vote.
          resync_d    = 3'b111;
          timer_d     = TW'(RESYNC_CYCLES - 1);
          state_d     = ST_RESYNC;
        end
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Combinational so fault-free counting adds no enable latency.
  assign cnt_enable    = run_req & ((state_q == ST_RUN) || (state_q == ST_DEGRADED));
  assign resync        = resync_q;
  assign lane_mask     = lane_mask_q;
  assign state         = state_q;
  assign err_count     = err_count_q;
  assign uncorrectable = unc_q;

endmodule

// File: tb/tb_tmr_fault_manager.sv
// -----------------------------------------------------------------------------
// tb_tmr_fault_manager
//
// Directed bench for tmr_fault_manager (PERSIST_LIMIT=4, RESYNC_CYCLES=2,
// ERR_CNT_W=8). Inputs change on the falling edge; outputs are checked 2 ns
// later, so each row's expectations describe the cycle in which the row's
// inputs are present (before the next rising edge consumes them).
// -----------------------------------------------------------------------------
module tb_tmr_fault_manager;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       run_req;
  logic [2:0] fault;
  logic       clear_err;
  logic       cnt_enable;
  logic [2:0] resync;
  logic [2:0] lane_mask;
  logic [1:0] state;
  logic [7:0] err_count;
  logic       uncorrectable;

  always #5 clk = ~clk;

  tmr_fault_manager #(
    .WIDTH(4),
    .ERR_CNT_W(8),
    .PERSIST_LIMIT(4),
    .RESYNC_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run_req(run_req),
    .fault(fault),
    .clear_err(clear_err),
    .cnt_enable(cnt_enable),
    .resync(resync),
    .lane_mask(lane_mask),
    .state(state),
    .err_count(err_count),
    .uncorrectable(uncorrectable)
  );

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rr;
    logic [2:0] f;
    logic       ce;
    logic       en;
    logic [2:0] rs;
    logic [2:0] mk;
    logic [1:0] st;
    logic [7:0] ec;
    logic       unc;
  } vec_t;

  vec_t vecs[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void add(logic rr, logic [2:0] f, logic ce, logic en,
                              logic [2:0] rs, logic [2:0] mk, logic [1:0] st,
                              logic [7:0] ec, logic unc);
    vec_t v;
    v.rr = rr; v.f = f; v.ce = ce;
    v.en = en; v.rs = rs; v.mk = mk; v.st = st; v.ec = ec; v.unc = unc;
    vecs.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rr, input logic [2:0] f, input logic ce);
    @(negedge clk);
    run_req   = rr;
    fault     = f;
    clear_err = ce;
    #2;
  endtask

  task automatic check(input string name, input logic en, input logic [2:0] rs,
                       input logic [2:0] mk, input logic [1:0] st,
                       input logic [7:0] ec, input logic unc);
    n_vec++;
    if ({cnt_enable, resync, lane_mask, state, err_count, uncorrectable} !==
        {en, rs, mk, st, ec, unc}) begin
      n_err++;
      $display("FAIL %s: got en=%b rs=%b mk=%b st=%b ec=%0d unc=%b, want en=%b rs=%b mk=%b st=%b ec=%0d unc=%b",
               name, cnt_enable, resync, lane_mask, state, err_count, uncorrectable,
               en, rs, mk, st, ec, unc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0] f;

    rst       = 1'b1;
    run_req   = 1'b0;
    fault     = 3'b000;
    clear_err = 1'b0;

    //        rr  f       ce   en  rs      mk      st     ec   unc
    // Fault-free counting: enable follows run_req every cycle.
    for (int i = 0; i < 20; i++)
      add(1, 3'b000, 0,   1, 3'b000, 3'b000, 2'b00, 8'd0, 0);
    // Single pulse on lane 2: two resync cycles, then back to RUN.
    add(1, 3'b010, 0,   1, 3'b000, 3'b000, 2'b00, 8'd0, 0);
    add(1, 3'b000, 0,   0, 3'b010, 3'b000, 2'b01, 8'd1, 0);
    add(1, 3'b000, 0,   0, 3'b010, 3'b000, 2'b01, 8'd1, 0);
    add(1, 3'b000, 0,   1, 3'b000, 3'b000, 2'b00, 8'd1, 0);
    // clear_err in RUN without a fault: counter to 0.
    add(1, 3'b000, 1,   1, 3'b000, 3'b000, 2'b00, 8'd1, 0);
    // Lane 1 faults on four consecutive RUN evaluations (held throughout).
    add(1, 3'b001, 0,   1, 3'b000, 3'b000, 2'b00, 8'd0, 0);
    add(1, 3'b001, 0,   0, 3'b001, 3'b000, 2'b01, 8'd1, 0);
    add(1, 3'b001, 0,   0, 3'b001, 3'b000, 2'b01, 8'd1, 0);
    add(1, 3'b001, 0,   1, 3'b000, 3'b000, 2'b00, 8'd1, 0);
    add(1, 3'b001, 0,   0, 3'b001, 3'b000, 2'b01, 8'd2, 0);
    add(1, 3'b001, 0,   0, 3'b001, 3'b000, 2'b01, 8'd2, 0);
    add(1, 3'b001, 0,   1, 3'b000, 3'b000, 2'b00, 8'd2, 0);
    add(1, 3'b001, 0,   0, 3'b001, 3'b000, 2'b01, 8'd3, 0);
    add(1, 3'b001, 0,   0, 3'b001, 3'b000, 2'b01, 8'd3, 0);
    add(1, 3'b001, 0,   1, 3'b000, 3'b000, 2'b00, 8'd3, 0);
    // 4th evaluation masked lane 1: DEGRADED, no resync, masked fault ignored.
    add(1, 3'b001, 0,   1, 3'b000, 3'b001, 2'b10, 8'd4, 0);
    // Fault on lane 3 while degraded: uncorrectable, HALT.
    add(1, 3'b100, 0,   1, 3'b000, 3'b001, 2'b10, 8'd4, 0);
    add(1, 3'b000, 0,   0, 3'b000, 3'b001, 2'b11, 8'd4, 1);
    add(1, 3'b010, 0,   0, 3'b000, 3'b001, 2'b11, 8'd4, 1);
    // Recovery from HALT: all lanes resync for 2 cycles, state cleared.
    add(1, 3'b000, 1,   0, 3'b000, 3'b001, 2'b11, 8'd4, 1);
    add(1, 3'b000, 0,   0, 3'b111, 3'b000, 2'b01, 8'd0, 0);
    add(1, 3'b000, 0,   0, 3'b111, 3'b000, 2'b01, 8'd0, 0);
    add(1, 3'b000, 0,   1, 3'b000, 3'b000, 2'b00, 8'd0, 0);
    // Lane 3 single fault, then a double fault: err_count must not move.
    add(1, 3'b100, 0,   1, 3'b000, 3'b000, 2'b00, 8'd0, 0);
    add(1, 3'b000, 0,   0, 3'b100, 3'b000, 2'b01, 8'd1, 0);
    add(1, 3'b000, 0,   0, 3'b100, 3'b000, 2'b01, 8'd1, 0);
    add(1, 3'b011, 0,   1, 3'b000, 3'b000, 2'b00, 8'd1, 0);
    add(1, 3'b000, 0,   0, 3'b000, 3'b000, 2'b11, 8'd1, 1);
    add(1, 3'b000, 1,   0, 3'b000, 3'b000, 2'b11, 8'd1, 1);
    add(1, 3'b000, 0,   0, 3'b111, 3'b000, 2'b01, 8'd0, 0);
    add(1, 3'b000, 0,   0, 3'b111, 3'b000, 2'b01, 8'd0, 0);
    add(1, 3'b000, 0,   1, 3'b000, 3'b000, 2'b00, 8'd0, 0);
    // run_req low in RUN: enable low.
    add(0, 3'b000, 0,   0, 3'b000, 3'b000, 2'b00, 8'd0, 0);
    add(1, 3'b000, 0,   1, 3'b000, 3'b000, 2'b00, 8'd0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    #2;
    check("reset", 1'b0, 3'b000, 3'b000, 2'b00, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].rr, vecs[i].f, vecs[i].ce);
      check($sformatf("vec%0d", i), vecs[i].en, vecs[i].rs, vecs[i].mk,
            vecs[i].st, vecs[i].ec, vecs[i].unc);
    end

    // Saturation: 300 isolated single-lane faults rotated over the lanes,
    // each followed by the two resync cycles and a clean RUN cycle.
    for (int i = 0; i < 300; i++) begin
      f = 3'b001 << (i % 3);
      drive(1, f, 0);
      repeat (3) drive(1, 3'b000, 0);
    end
    drive(1, 3'b000, 0);
    check("saturate", 1'b1, 3'b000, 3'b000, 2'b00, 8'd255, 1'b0);

    // clear_err together with a correctable fault: count restarts at 1.
    drive(1, 3'b010, 1);
    check("clear_fault_pre", 1'b1, 3'b000, 3'b000, 2'b00, 8'd255, 1'b0);
    drive(1, 3'b000, 0);
    check("clear_with_fault", 1'b0, 3'b010, 3'b000, 2'b01, 8'd1, 1'b0);
    drive(1, 3'b000, 0);
    drive(1, 3'b000, 0);
    check("back_to_run", 1'b1, 3'b000, 3'b000, 2'b00, 8'd1, 1'b0);

    // Asynchronous reset during the first RESYNC cycle.
    drive(1, 3'b100, 0);
    drive(1, 3'b000, 0);
    check("resync_before_rst", 1'b0, 3'b100, 3'b000, 2'b01, 8'd2, 1'b0);
    run_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_reset", 1'b0, 3'b000, 3'b000, 2'b00, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 3'b000, 0);
      check($sformatf("post_reset%0d", k), 1'b1, 3'b000, 3'b000, 2'b00, 8'd0, 1'b0);
    end

    // Summary.
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
